// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_mmio
//  Description : Data memory for the single-cycle core. It provides a
//                word-addressed RAM and a memory-mapped I/O window.
//                The I/O window holds a debounced switch register, sticky
//                rising-edge flags that clear when read, and an LED register.
//                All reads are registered, so data appears one cycle after
//                the address.
//  Build macro : DMEM_MMIO_DEBOUNCE_EN
//                - defined:   each switch bit has a counter-based debouncer.
//                - undefined: the debounced switch value is the output of
//                             the 2-FF synchroniser.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_mmio #(
    parameter int          DEPTH    = 64,
    parameter logic [31:0] IO_BASE  = 32'h100,
    parameter int          N_SW     = 2,
    parameter int          N_LED    = 8,
    parameter int          DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [31:0]      a,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    input  logic [N_SW-1:0]  sw,
    output logic [N_LED-1:0] led
);

    localparam int          c_addr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_depth     = 32'(DEPTH);
    localparam logic [29:0] c_sw_word   = IO_BASE[31:2];
    localparam logic [29:0] c_edge_word = IO_BASE[31:2] + 30'd1;
    localparam logic [29:0] c_led_word  = IO_BASE[31:2] + 30'd2;

    // ------------------------------------------------------------------
    // Address decode (word granularity; byte offset bits are ignored)
    // ------------------------------------------------------------------
    logic [29:0]         w_word;
    logic                w_is_ram;
    logic                w_is_sw;
    logic                w_is_edge;
    logic                w_is_led;
    logic [c_addr_w-1:0] w_ram_idx;

    assign w_word    = a[31:2];
    assign w_is_ram  = ({2'b00, w_word} < c_depth);
    assign w_is_sw   = (w_word == c_sw_word);
    assign w_is_edge = (w_word == c_edge_word);
    assign w_is_led  = (w_word == c_led_word);
    assign w_ram_idx = w_word[c_addr_w-1:0];

    // The byte-offset bits and the debounce length are unused in some builds.
    logic w_unused;
    assign w_unused = ^{a[1:0], 32'(DEBOUNCE)};

    // ------------------------------------------------------------------
    // RAM storage; contents deliberately not reset
    // ------------------------------------------------------------------
    logic [31:0] r_mem [DEPTH];

    // Write port: only addresses inside the RAM range are stored
    always_ff @(posedge clk) begin
        if (we && w_is_ram) begin
            r_mem[w_ram_idx] <= wd;
        end
    end

    // ------------------------------------------------------------------
    // Switch path: synchroniser, optional debouncer, edge flags
    // ------------------------------------------------------------------
    logic [N_SW-1:0] r_sync1;
    logic [N_SW-1:0] r_db;
    logic [N_SW-1:0] w_db_next;
    logic [N_SW-1:0] r_edge;
    logic [N_SW-1:0] w_rise;
    logic [N_SW-1:0] w_clr;

    // First synchroniser stage for the asynchronous switch inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
        end else begin
            r_sync1 <= sw;
        end
    end

`ifdef DMEM_MMIO_DEBOUNCE_EN
    localparam int                 c_cnt_w    = $clog2(DEBOUNCE + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE - 1);

    logic [N_SW-1:0] r_sync2;

    // Second synchroniser stage; this is what the debouncer watches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync2 <= '0;
        end else begin
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_debounce
        logic [c_cnt_w-1:0] r_cnt;
        logic               w_differ;
        logic               w_settled;

        assign w_differ  = r_sync2[gi] ^ r_db[gi];
        // The DEBOUNCE-th consecutive disagreement accepts the new level
        assign w_settled = w_differ && (r_cnt == c_cnt_last);

        // Count consecutive disagreeing cycles; agreement or acceptance restarts it
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (!w_differ || w_settled) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_db_next[gi] = r_db[gi] ^ w_settled;
    end
`else
    // Without the debouncer, r_db acts as the second synchroniser stage
    assign w_db_next = r_sync1;
`endif

    assign w_rise = w_db_next & ~r_db;
    assign w_clr  = {N_SW{re && w_is_edge}};

    // Debounced switch register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db <= '0;
        end else begin
            r_db <= w_db_next;
        end
    end

    // Sticky rise flags; a rise in the same cycle as a read-clear keeps the flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge <= '0;
        end else begin
            r_edge <= (r_edge & ~w_clr) | w_rise;
        end
    end

    // ------------------------------------------------------------------
    // LED register and registered read mux
    // ------------------------------------------------------------------

    // LED register loads the low bits of the write data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led <= '0;
        end else if (we && w_is_led) begin
            led <= wd[N_LED-1:0];
        end
    end

    // Read data follows the address every cycle and returns pre-write values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd <= '0;
        end else if (w_is_ram) begin
            rd <= r_mem[w_ram_idx];
        end else if (w_is_sw) begin
            rd <= 32'(r_db);
        end else if (w_is_edge) begin
            rd <= 32'(r_edge);
        end else if (w_is_led) begin
            rd <= 32'(led);
        end else begin
            rd <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_mmio
//  Description : Self-checking bench for dmem_mmio. It combines a directed
//                vector table, hand-written multi-cycle sequences, and random
//                traffic checked against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_mmio;

    localparam int          DEPTH    = 64;
    localparam logic [31:0] IO_BASE  = 32'h100;
    localparam int          N_SW     = 2;
    localparam int          N_LED    = 8;
    localparam int          DEBOUNCE = 4;

`ifdef DMEM_MMIO_DEBOUNCE_EN
    localparam int LAG = 2;
    localparam int WIN = DEBOUNCE;
`else
    localparam int LAG = 1;
    localparam int WIN = 1;
`endif
    localparam int LAT = LAG + WIN;

    localparam logic [29:0] W_SW   = IO_BASE[31:2];
    localparam logic [29:0] W_EDGE = IO_BASE[31:2] + 30'd1;
    localparam logic [29:0] W_LED  = IO_BASE[31:2] + 30'd2;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             we    = 1'b0;
    logic             re    = 1'b0;
    logic [31:0]      a     = '0;
    logic [31:0]      wd    = '0;
    logic [31:0]      rd;
    logic [N_SW-1:0]  sw    = '0;
    logic [N_LED-1:0] led;

    always #5 clk = ~clk;

    dmem_mmio #(
        .DEPTH   (DEPTH),
        .IO_BASE (IO_BASE),
        .N_SW    (N_SW),
        .N_LED   (N_LED),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .re   (re),
        .a    (a),
        .wd   (wd),
        .rd   (rd),
        .sw   (sw),
        .led  (led)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [31:0]      m_mem [DEPTH];
    bit               m_val [DEPTH];
    logic [N_SW-1:0]  m_db;
    logic [N_SW-1:0]  m_edge;
    logic [N_LED-1:0] m_led;
    logic [N_SW-1:0]  m_hist [$];   // m_hist[k] = sw sampled k edges ago

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] a;
        logic [31:0] wd;
        bit          chk;
        logic [31:0] rd;
        logic [7:0]  led;
    } vec_t;

    vec_t vt [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_db   = '0;
        m_edge = '0;
        m_led  = '0;
        m_hist.delete();
        for (int k = 0; k < LAT; k++) m_hist.push_back('0);
    endtask

    // Drive one cycle, advance the model, and optionally compare against it
    task automatic cycle(input logic t_we, input logic t_re, input logic [31:0] t_a,
                         input logic [31:0] t_wd, input logic [N_SW-1:0] t_sw, input bit use_model);
        logic [29:0]     word;
        logic [31:0]     exp_rd;
        bit              exp_ok;
        logic [N_SW-1:0] nd;
        bit              flip;
        we = t_we; re = t_re; a = t_a; wd = t_wd; sw = t_sw;
        word   = t_a[31:2];
        exp_ok = 1'b1;
        if (word < DEPTH) begin
            exp_rd = m_mem[word];
            exp_ok = m_val[word];
        end else if (word == W_SW)   exp_rd = 32'(m_db);
        else if (word == W_EDGE)     exp_rd = 32'(m_edge);
        else if (word == W_LED)      exp_rd = 32'(m_led);
        else                         exp_rd = 32'h0;
        // A bit's debounced value flips once the last WIN synchronised samples all disagree with it
        m_hist.push_front(t_sw);
        nd = m_db;
        for (int i = 0; i < N_SW; i++) begin
            flip = 1'b1;
            for (int j = 0; j < WIN; j++) if (m_hist[LAG + j][i] == m_db[i]) flip = 1'b0;
            if (flip) nd[i] = ~m_db[i];
        end
        void'(m_hist.pop_back());
        if (t_re && word == W_EDGE) m_edge = '0;
        m_edge = m_edge | (nd & ~m_db);
        m_db   = nd;
        if (t_we && word < DEPTH) begin
            m_mem[word] = t_wd;
            m_val[word] = 1'b1;
        end
        if (t_we && word == W_LED) m_led = t_wd[N_LED-1:0];
        @(posedge clk);
        #1;
        if (use_model) begin
            if (exp_ok) check("model_rd", rd, exp_rd);
            check("model_led", 32'(led), 32'(m_led));
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0, 1, 2: rand_addr = {24'h0, 3'($urandom_range(0, 7)), 3'b000} | 32'($urandom_range(0, 3)) | 32'h20;
            3:       rand_addr = IO_BASE;
            4:       rand_addr = IO_BASE + 32'd4;
            5:       rand_addr = IO_BASE + 32'd8;
            6:       rand_addr = IO_BASE + 32'd12;
            default: rand_addr = 32'h1000 + 32'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic random_phase(input int n);
        logic [N_SW-1:0] s;
        s = sw;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 9) == 0) s = N_SW'($urandom);
            cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, s, 1'b1);
        end
    endtask

    initial begin
        // Directed table: inputs with the expected rd (after the edge) and led
        vt.push_back('{1'b1, 1'b0, 32'h8,            32'hDEADBEEF, 1'b0, 32'h0,        8'h00});
        vt.push_back('{1'b1, 1'b0, 32'h4,            32'h0,        1'b0, 32'h0,        8'h00});
        vt.push_back('{1'b0, 1'b0, 32'h8,            32'h0,        1'b1, 32'hDEADBEEF, 8'h00});
        vt.push_back('{1'b0, 1'b0, 32'h4,            32'h0,        1'b1, 32'h0,        8'h00});
        vt.push_back('{1'b1, 1'b0, IO_BASE + 32'd8,  32'hFFFFFFA5, 1'b1, 32'h0,        8'hA5});
        vt.push_back('{1'b0, 1'b0, IO_BASE + 32'd8,  32'h0,        1'b1, 32'h000000A5, 8'hA5});
        vt.push_back('{1'b0, 1'b0, IO_BASE + 32'd12, 32'h0,        1'b1, 32'h0,        8'hA5});
        vt.push_back('{1'b1, 1'b0, IO_BASE,          32'hFFFFFFFF, 1'b1, 32'h0,        8'hA5});
        vt.push_back('{1'b0, 1'b0, IO_BASE,          32'h0,        1'b1, 32'h0,        8'hA5});
        vt.push_back('{1'b1, 1'b0, 32'h8,            32'h1,        1'b1, 32'hDEADBEEF, 8'hA5});
        vt.push_back('{1'b1, 1'b0, 32'h8,            32'h2,        1'b1, 32'h1,        8'hA5});
        vt.push_back('{1'b0, 1'b0, 32'h8,            32'h0,        1'b1, 32'h2,        8'hA5});
        vt.push_back('{1'b1, 1'b0, 32'h200,          32'hFF,       1'b1, 32'h0,        8'hA5});
        vt.push_back('{1'b0, 1'b0, 32'h200,          32'h0,        1'b1, 32'h0,        8'hA5});
        vt.push_back('{1'b0, 1'b0, 32'hB,            32'h0,        1'b1, 32'h2,        8'hA5});
        vt.push_back('{1'b0, 1'b1, IO_BASE + 32'd4,  32'h0,        1'b1, 32'h0,        8'hA5});
        vt.push_back('{1'b1, 1'b0, IO_BASE + 32'd8,  32'h1234563C, 1'b1, 32'hA5,       8'h3C});
        vt.push_back('{1'b0, 1'b0, IO_BASE + 32'd9,  32'h0,        1'b1, 32'h3C,       8'h3C});

        // Reset state
        #1 reset = 1'b1;
        #2;
        check("reset_rd_init", rd, 32'h0);
        check("reset_led_init", 32'(led), 32'h0);
        #19 reset = 1'b0;
        model_reset();

        // Directed table
        for (int i = 0; i < vt.size(); i++) begin
            cycle(vt[i].we, vt[i].re, vt[i].a, vt[i].wd, '0, 1'b0);
            if (vt[i].chk) check($sformatf("vec%0d_rd", i), rd, vt[i].rd);
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vt[i].led));
        end

        // Switch latency: rd shows the new value LAT edges after the change is first sampled
        for (int k = 0; k <= LAT; k++) begin
            cycle(1'b0, 1'b0, IO_BASE, 32'h0, 2'b01, 1'b1);
            if (k == LAT - 1) check("sw_before_latency", rd, 32'h0);
            if (k == LAT)     check("sw_at_latency", rd, 32'h1);
        end

        // Edge flag read and clear
        cycle(1'b0, 1'b1, IO_BASE + 32'd4, 32'h0, 2'b01, 1'b1);
        check("edge_read_set", rd, 32'h1);
        cycle(1'b0, 1'b1, IO_BASE + 32'd4, 32'h0, 2'b01, 1'b1);
        check("edge_read_cleared", rd, 32'h0);

        // A rise coinciding with a read-clear keeps the flag
        for (int k = 0; k < LAT; k++) begin
            cycle(1'b0, (k == LAT - 1), IO_BASE + 32'd4, 32'h0, 2'b11, 1'b1);
            if (k == LAT - 1) check("edge_coinc_old", rd, 32'h0);
        end
        cycle(1'b0, 1'b1, IO_BASE + 32'd4, 32'h0, 2'b11, 1'b1);
        check("edge_coinc_kept", rd, 32'h2);
        cycle(1'b0, 1'b1, IO_BASE + 32'd4, 32'h0, 2'b11, 1'b1);
        check("edge_coinc_cleared", rd, 32'h0);

        // Falling switches never set edge flags
        for (int k = 0; k <= LAT + 1; k++) cycle(1'b0, 1'b0, IO_BASE, 32'h0, 2'b00, 1'b1);
        check("sw_fell", rd, 32'h0);
        cycle(1'b0, 1'b1, IO_BASE + 32'd4, 32'h0, 2'b00, 1'b1);
        check("edge_no_fall", rd, 32'h0);

        // Three-cycle pulse on bit 0
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, IO_BASE, 32'h0, 2'b01, 1'b1);
        for (int k = 0; k < LAT + 3; k++) begin
            cycle(1'b0, 1'b0, IO_BASE, 32'h0, 2'b00, 1'b1);
`ifdef DMEM_MMIO_DEBOUNCE_EN
            check("glitch_rejected", rd, 32'h0);
`endif
        end

        random_phase(600);

        // Asynchronous reset in the middle of a debounce
        cycle(1'b1, 1'b0, IO_BASE + 32'd8, 32'h000000A5, 2'b00, 1'b1);
        cycle(1'b0, 1'b0, IO_BASE + 32'd8, 32'h0, 2'b01, 1'b1);
        cycle(1'b0, 1'b0, IO_BASE + 32'd8, 32'h0, 2'b01, 1'b1);
        check("pre_reset_rd", rd, 32'hA5);
        #2 reset = 1'b1;
        #1;
        check("async_reset_led", 32'(led), 32'h0);
        check("async_reset_rd", rd, 32'h0);
        check("async_reset_sw", 32'(dut.r_db), 32'h0);
        check("async_reset_edge", 32'(dut.r_edge), 32'h0);
        @(posedge clk);
        #4 reset = 1'b0;
        model_reset();
        cycle(1'b0, 1'b0, IO_BASE, 32'h0, 2'b01, 1'b1);
        check("post_reset_sw", rd, 32'h0);
        cycle(1'b0, 1'b1, IO_BASE + 32'd4, 32'h0, 2'b01, 1'b1);
        check("post_reset_edge", rd, 32'h0);

        random_phase(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
